serial_sum_deserializer: RTL

- Downstream of the bit-serial adder in the serial CIC datapath.
- Collects the LSB-first sum bit stream plus the final carry, and reassembles each N-bit word.
- Buffers completed words in a small FIFO and presents them on a valid/ready parallel interface to the next CIC stage or register bank.
- Detects framing errors and reports words dropped due to back-pressure.

---
 rtl/serial_sum_deserializer.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/serial_sum_deserializer.sv
// Reassembles LSB-first bit-serial sums into N-bit words behind a small FIFO.
// Define SER_DESER_STATUS_EN to add saturating error/drop counters.
module serial_sum_deserializer #(
  parameter int N     = 8,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         bit_valid,
  input  logic         bit_sof,
  input  logic         bit_data,
  input  logic         carry_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_word,
  output logic         out_carry,
  output logic         busy,
  output logic         frame_err,
  output logic         drop
`ifdef SER_DESER_STATUS_EN
  ,
  input  logic         stat_clr,
  output logic [7:0]   err_cnt,
  output logic [7:0]   drop_cnt
`endif
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam int AW = $clog2(DEPTH);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt, cnt_nxt, cnt_base;
  logic [N-1:0]    shreg, shift_in, sh_nxt;
  logic            acc, last, err_nxt;

  logic [N:0]      mem [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [AW:0]     occ;
  logic            full, pop, push, drop_nxt;

  generate
    if (N == 1) begin : g_one
      assign shift_in = bit_data;
    end else begin : g_many
      assign shift_in = {bit_data, shreg[N-1:1]};
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    cnt_base  = cnt;
    sh_nxt    = shreg;
    acc       = 1'b0;
    last      = 1'b0;
    err_nxt   = 1'b0;
    if (bit_valid) begin
      case (state)
        IDLE: begin
          acc     = bit_sof;
          err_nxt = !bit_sof;
        end
        SHIFT: begin
          acc     = 1'b1;
          err_nxt = bit_sof;
        end
        default: ;
      endcase
    end
    // A sof always restarts the count; stale bits shift out over N accepts.
    if (acc) begin
      cnt_base = bit_sof ? '0 : cnt;
      sh_nxt   = shift_in;
      last     = (cnt_base == LAST);
      if (last) begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end else begin
        state_nxt = SHIFT;
        cnt_nxt   = cnt_base + CW'(1);
      end
    end
  end

  assign busy      = (state == SHIFT);
  assign out_valid = (occ != '0);
  assign full      = (occ == (AW+1)'(DEPTH));
  assign pop       = out_valid & out_ready;
  assign push      = last & (!full | pop);
  assign drop_nxt  = last & full & !pop;
  assign {out_carry, out_word} = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt       <= '0;
      shreg     <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occ       <= '0;
      frame_err <= 1'b0;
      drop      <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      cnt       <= cnt_nxt;
      shreg     <= sh_nxt;
      frame_err <= err_nxt;
      drop      <= drop_nxt;
      if (push) begin
        mem[wr_ptr] <= {carry_in, shift_in};
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   occ <= occ + (AW+1)'(1);
        2'b01:   occ <= occ - (AW+1)'(1);
        default: ;
      endcase
    end
  end

`ifdef SER_DESER_STATUS_EN
  always_ff @(posedge clk) begin
    if (!rst_n || stat_clr) begin
      err_cnt  <= '0;
      drop_cnt <= '0;
    end else begin
      if (err_nxt && err_cnt != 8'hFF)   err_cnt  <= err_cnt + 8'd1;
      if (drop_nxt && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
    end
  end
`endif

endmodule
